// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - data-memory bus seen by the interrupt controller register window
// The core drives address, write data and write enable; the controller returns read data.
interface irq_ctrl_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output addr, output wd, input rd);
  modport slave  (input we, input addr, input wd, output rd);
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller driving the CP0 INT[4:0] lines
// Sources are synchronised, latched as pending, masked, routed and ORed onto registered lines.
module irq_ctrl #(
  parameter int          N_SRC     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  irq_ctrl_if.slave        bus,
  output logic [4:0]       INT
);

  localparam int          PAD     = 32 - N_SRC;
  localparam logic [26:0] BASE_HI = BASE_ADDR[31:5];
  // Route fields of sources that do not exist stay zero.
  localparam logic [59:0] MAP_MSK = (60'd1 << (3 * N_SRC)) - 60'd1;

  localparam logic [2:0] OFF_PEND  = 3'd0;
  localparam logic [2:0] OFF_MASK  = 3'd1;
  localparam logic [2:0] OFF_EDGE  = 3'd2;
  localparam logic [2:0] OFF_MAP0  = 3'd3;
  localparam logic [2:0] OFF_MAP1  = 3'd4;
  localparam logic [2:0] OFF_VECT  = 3'd5;
  localparam logic [2:0] OFF_FORCE = 3'd6;

  logic [N_SRC-1:0] r_s1, r_s2, r_s3;
  logic [N_SRC-1:0] r_pend, r_mask, r_edge;
  logic [59:0]      r_map;

  logic             w_hit;
  logic [2:0]       w_off;
  logic             w_wr;
  logic [N_SRC-1:0] w_wd_n;
  logic [N_SRC-1:0] w_set, w_clr, w_pend_nxt, w_act;
  logic [4:0]       w_int_nxt;
  logic [4:0]       w_id;
  logic             w_unused;

  assign w_hit  = (bus.addr[31:5] == BASE_HI);
  assign w_off  = bus.addr[4:2];
  assign w_wr   = bus.we & w_hit;
  assign w_wd_n = bus.wd[N_SRC-1:0];
  assign w_unused = ^{bus.addr[1:0], bus.wd[31:30]};

  // Edge sources: set wins over a same-cycle W1C. Level sources just track s2.
  assign w_set = (r_s2 & ~r_s3) | ({N_SRC{w_wr && w_off == OFF_FORCE}} & w_wd_n);
  assign w_clr = {N_SRC{w_wr && w_off == OFF_PEND}} & w_wd_n;
  assign w_pend_nxt = (r_edge & (w_set | (r_pend & ~w_clr))) | (~r_edge & r_s2);
  assign w_act = r_pend & r_mask;

  always_comb begin
    logic [2:0] rt;
    w_int_nxt = '0;
    w_id      = 5'h1F;
    rt        = '0;
    // Walk downwards so the lowest-numbered eligible source owns the vector.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      rt = r_map[3*i +: 3];
      if (w_act[i] && rt < 3'd5) begin
        w_id = i[4:0];
        for (int k = 0; k < 5; k++) begin
          if (rt == 3'(k)) w_int_nxt[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    if (w_hit) begin
      case (w_off)
        OFF_PEND: bus.rd = {{PAD{1'b0}}, r_pend};
        OFF_MASK: bus.rd = {{PAD{1'b0}}, r_mask};
        OFF_EDGE: bus.rd = {{PAD{1'b0}}, r_edge};
        OFF_MAP0: bus.rd = {2'b00, r_map[29:0]};
        OFF_MAP1: bus.rd = {2'b00, r_map[59:30]};
        OFF_VECT: bus.rd = {27'b0, w_id};
        default:  bus.rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_pend <= '0;
      r_mask <= '0;
      r_edge <= '1;
      r_map  <= '0;
      INT    <= '0;
    end else begin
      r_s1   <= src;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_nxt;
      INT    <= w_int_nxt;
      if (w_wr) begin
        case (w_off)
          OFF_MASK: r_mask        <= w_wd_n;
          OFF_EDGE: r_edge        <= w_wd_n;
          OFF_MAP0: r_map[29:0]   <= bus.wd[29:0] & MAP_MSK[29:0];
          OFF_MAP1: r_map[59:30]  <= bus.wd[29:0] & MAP_MSK[59:30];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed bench for irq_ctrl with hand-computed expectations
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_irq_ctrl;

  localparam logic [31:0] A_PEND  = 32'h800;
  localparam logic [31:0] A_MASK  = 32'h804;
  localparam logic [31:0] A_EDGE  = 32'h808;
  localparam logic [31:0] A_MAP0  = 32'h80C;
  localparam logic [31:0] A_MAP1  = 32'h810;
  localparam logic [31:0] A_VECT  = 32'h814;
  localparam logic [31:0] A_FORCE = 32'h818;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] src = '0;
  logic [4:0]  int_o;
  int          n_chk = 0;
  int          n_err = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(16), .BASE_ADDR(32'h0000_0800)) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus),
    .INT (int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.wd   = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rd, exp);
  endtask

  initial begin
    bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
    src = 16'hFFFF;
    rst = 1'b0;
    step(3);
    chk("rst_int", {27'b0, int_o}, 32'h0);
    chk_rd("rst_pend", A_PEND, 32'h0);
    chk_rd("rst_mask", A_MASK, 32'h0);
    chk_rd("rst_edge", A_EDGE, 32'h0000FFFF);
    chk_rd("rst_vect", A_VECT, 32'h1F);
    rst = 1'b1;
    step(2);
    chk_rd("rel_pend_e1", A_PEND, 32'h0);
    step(1);
    chk_rd("rel_pend_e2", A_PEND, 32'h0000FFFF);
    step(2);
    chk("rel_int", {27'b0, int_o}, 32'h0);
    src = '0;
    wr(A_PEND, 32'hFFFF);
    chk_rd("clr_all", A_PEND, 32'h0);

    // edge latency and clear
    wr(A_MASK, 32'h8);
    wr(A_MAP0, 32'h400);
    src[3] = 1'b1;
    step(3);
    src[3] = 1'b0;
    chk("lat_e2", {27'b0, int_o}, 32'h0);
    step(1);
    chk("lat_e3", {27'b0, int_o}, 32'h4);
    chk_rd("lat_vect", A_VECT, 32'h3);
    wr(A_PEND, 32'h8);
    chk_rd("clr_vect", A_VECT, 32'h1F);
    step(1);
    chk("clr_int", {27'b0, int_o}, 32'h0);

    // set and clear on the same edge
    wr(A_MASK, 32'h1);
    src[0] = 1'b1;
    step(2);
    wr(A_PEND, 32'h1);
    chk_rd("col_pend", A_PEND, 32'h1);
    step(1);
    chk("col_int", {27'b0, int_o}, 32'h1);
    src[0] = 1'b0;
    wr(A_PEND, 32'h1);
    step(1);
    chk("col_clr_int", {27'b0, int_o}, 32'h0);

    // level mode
    wr(A_EDGE, 32'h0);
    wr(A_MASK, 32'h2);
    wr(A_MAP0, 32'h20);
    src[1] = 1'b1;
    step(4);
    chk("lvl_int", {27'b0, int_o}, 32'h10);
    wr(A_PEND, 32'h2);
    chk_rd("lvl_w1c", A_PEND, 32'h2);
    step(1);
    chk("lvl_int_hold", {27'b0, int_o}, 32'h10);
    src[1] = 1'b0;
    step(3);
    chk("lvl_fall_e2", {27'b0, int_o}, 32'h10);
    step(1);
    chk("lvl_fall_e3", {27'b0, int_o}, 32'h0);
    wr(A_EDGE, 32'hFFFF);

    // routing and priority
    wr(A_MASK, 32'h1020);
    wr(A_MAP0, 32'h8000);
    wr(A_MAP1, 32'h40);
    src = 16'h1020;
    step(4);
    chk("rt_int", {27'b0, int_o}, 32'h2);
    chk_rd("rt_vect", A_VECT, 32'h5);
    wr(A_MAP1, 32'h1C0);
    chk_rd("rt_map1", A_MAP1, 32'h1C0);
    chk_rd("rt_vect_r7", A_VECT, 32'h5);
    src = '0;
    wr(A_PEND, 32'h20);
    chk_rd("rt_vect_none", A_VECT, 32'h1F);
    step(1);
    chk("rt_int_none", {27'b0, int_o}, 32'h0);
    chk_rd("rt_pend12", A_PEND, 32'h1000);
    wr(A_PEND, 32'h1000);

    // force and decode
    wr(A_MAP0, 32'h0);
    wr(A_MASK, 32'h10);
    wr(A_FORCE, 32'h10);
    chk_rd("frc_pend", A_PEND, 32'h10);
    chk("frc_int_w", {27'b0, int_o}, 32'h0);
    step(1);
    chk("frc_int_w1", {27'b0, int_o}, 32'h1);
    wr(32'h840, 32'hFFFF_FFFF);
    chk_rd("miss_mask", A_MASK, 32'h10);
    chk_rd("miss_pend", A_PEND, 32'h10);
    chk_rd("miss_rd", 32'h840, 32'h0);
    chk_rd("rd_1c", 32'h81C, 32'h0);
    chk_rd("rd_force", A_FORCE, 32'h0);
    wr(A_MASK, 32'hFFFF_FFFF);
    chk_rd("mask_width", A_MASK, 32'h0000FFFF);

    // asynchronous reset mid-run
    rst = 1'b0;
    #1;
    chk("arst_int", {27'b0, int_o}, 32'h0);
    chk_rd("arst_pend", A_PEND, 32'h0);
    chk_rd("arst_edge", A_EDGE, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that produces the 5-bit external interrupt vector (INT) consumed by the MIPS core's CP0.
- Collects up to 20 peripheral request lines, synchronises them and latches them as pending.
- Applies per-source mask, edge/level mode and line routing, and drives INT[4:0] as registered outputs.
- Sits on the data-memory bus: the core's address, write data and write enable come in; read data goes back to the core.

Parameters:
- N_SRC, 16, number of peripheral interrupt sources (1..20).
- BASE_ADDR, 32'h0000_0800, byte base address of the register window (32-byte aligned).

Ports:
- clk, input, 1, system clock; all flops on rising edge.
- rst, input, 1, asynchronous, active-low reset.
- src, input, N_SRC, raw peripheral requests, asynchronous to clk.
- we, input, 1, data-memory write enable from the core.
- addr, input, 32, data-memory byte address (core ALU result).
- wd, input, 32, data-memory write data.
- rd, output, 32, read data; combinational.
- INT, output, 5, interrupt lines to the core; registered.

Behaviour:
- Hit: addr[31:5] == BASE_ADDR[31:5]. The register offset is addr[4:2]. On a miss, rd = 0 and writes are ignored.
- Register map. Unused bits above N_SRC read 0 and ignore writes.
  - 0x00 PEND: read = pending bits; write-1-to-clear (edge-mode sources only).
  - 0x04 MASK: RW. Reset 0.
  - 0x08 EDGE: RW; 1 = edge-triggered, 0 = level. Reset all ones.
  - 0x0C MAP0: RW; 3-bit route fields, source i at bits [3i+2:3i] for i = 0..9. Reset 0.
  - 0x10 MAP1: RW; same layout for sources 10..19. Reset 0.
  - Route values: 0..4 select INT line; 5..7 = source never drives any line.
  - 0x14 VECT: RO. {27'b0, id}, where id = lowest-numbered source with pend & mask & route<5; id = 5'h1F if none.
  - 0x18 FORCE: WO, reads 0. Write-1 sets PEND of edge-mode sources (software trigger).
  - 0x1C: reads 0; writes ignored.
- Writes take effect on the rising edge when the address hits and we = 1. Reads are combinational from current register state (single-cycle core, no wait states).
- Synchroniser: src passes through two flops (s1, s2). A third flop s3 holds the previous s2.
- Edge-mode source i: pending is set on the edge where s2 = 1 and s3 = 0, or on a FORCE write with bit i = 1.
  - Pending is cleared by a PEND write with bit i = 1.
  - Set and clear in the same cycle: set wins; no event is lost.
- Level-mode source i: pend[i] <= s2[i] every cycle. W1C and FORCE have no effect.
- Mode change EDGE 1->0: pend follows the level from the next edge. Mode change 0->1: current pend is kept until cleared.
- Output: INT[k] <= OR over i of (pend[i] & mask[i] & route[i] == k), registered.
- Latency: src rises before edge E0 -> s1 at E0, s2 at E1, pend at E2, INT at E3.
  - A MASK/MAP write at edge W affects INT at edge W+1.
  - A PEND clear at edge W drops INT at W+1, unless another routed source is still pending.
- Pulses shorter than one clk period may be missed; sources must hold at least 2 cycles.
- Reset (rst = 0, any time, including mid-write): all flops cleared asynchronously.
  - s1/s2/s3 = 0, PEND = 0, MASK = 0, MAP0/MAP1 = 0, EDGE = all ones.
  - INT = 5'b0 immediately; rd reflects reset state.
  - After release, a source that is already high is seen as a rising edge (s3 = 0) and sets pending.
- No internal FSM beyond the per-source synchroniser/edge pipeline.

Test Plan:
- Reset state: hold rst = 0, src = all ones. Expect INT = 0, PEND = 0, MASK = 0, EDGE reads 0x0000FFFF, VECT = 0x1F. Release rst: PEND = 0xFFFF after 3 edges; INT stays 0 (MASK = 0).
- Edge latency and clear: MASK = 0x0008, MAP0 source 3 = line 2, then pulse src[3] high for 3 cycles. Expect INT = 5'b00100 exactly 4 edges after the rise, VECT = 3. Write PEND = 0x0008: INT = 0 at the next edge, VECT = 0x1F.
- Set/clear collision: edge on src[0] reaches pend on the same edge as a PEND W1C of bit 0. Expect PEND[0] = 1 and INT[route0] asserted.
- Level mode: EDGE = 0, MASK = 0x0002, MAP0 source 1 = line 4. Hold src[1] high: INT[4] = 1; W1C PEND has no effect. Drop src[1]: INT[4] = 0 after 4 edges.
- Routing/priority: sources 5 and 12 pending and masked, routed to lines 1 and 1. Expect INT = 5'b00010, VECT = 5. Route source 12 to 7: VECT still 5. Clear 5: INT = 0, VECT = 0x1F.
- FORCE and decode: write FORCE = 0x0010 with MASK = 0x0010. Expect PEND[4] = 1 next edge and INT asserted the edge after. A write to BASE_ADDR + 0x40 changes nothing. A read of an unmapped address returns 0.
